onehot_scanner: RTL and testbench
=================================

# onehot_scanner

Parametrised sequential one-hot decoder for time-multiplexed loads such as multiplexed 7-segment digit enables, LED matrix columns and keypad row scanning. It holds a registered index and drives `Y = 1 << IDX`. A programmable prescaler steps the index up or down with wrap-around, and the index can be loaded directly from `SEL`. It sits between the system clock domain and the multiplexed display or scan drivers, and replaces fixed combinational decoders where a scan sequence is needed.

## Interface
Parameters:
- `N`, 8: number of one-hot outputs; must be ≥ 2; need not be a power of two.
- `M`, `$clog2(N)`: index and select width.
- `DIV_W`, 16: prescaler width.

Ports:
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `EN`, input, 1: enables the prescaler and stepping.
- `LOAD`, input, 1: load request; index becomes `SEL` on the next edge.
- `SEL`, input, M: index to load.
- `DIR`, input, 1: step direction; 0 = up, 1 = down.
- `DIV`, input, DIV_W: the index steps once every `DIV+1` enabled cycles.
- `Y`, output, N: one-hot decoded index, registered.
- `IDX`, output, M: current index, registered.
- `WRAP`, output, 1: one-cycle pulse when a step wraps (up from N-1 to 0, or down from 0 to N-1).
- `ERR`, output, 1: one-cycle pulse when a `LOAD` is rejected because `SEL ≥ N`.
- `BLANK`, input, 1: present only with `ONEHOT_SCANNER_BLANK_EN`.

## Operation
- State registers:
  - `IDX` (M bits).
  - Prescaler count `cnt` (DIV_W bits).
  - `Y`, `WRAP`, `ERR`.
- `Y` is always `1 << IDX`, so it is exactly one-hot and updates on the same edge as `IDX`. The only exception is blanking; see Configuration.
- Priority per edge is `RESET` > `LOAD` > step > hold.
- `RESET`:
  - `IDX = 0`, `Y = {{N-1}{0},1}`, `cnt = 0`, `WRAP = 0`, `ERR = 0`.
  - This applies regardless of the other inputs, including mid-count and mid-load.
- `LOAD` with `SEL < N`:
  - `IDX <= SEL`, `cnt <= 0`, `WRAP <= 0`.
  - No step occurs in that cycle, even if the prescaler was due.
- `LOAD` with `SEL ≥ N` (only possible when N is not a power of two):
  - `IDX` is held.
  - `cnt <= 0`.
  - `ERR` pulses high for 1 cycle.
- Step condition: `EN && !LOAD && cnt >= DIV`.
  - `cnt <= 0`.
  - `IDX` advances by ±1 according to `DIR`.
  - The comparison is `>=`, so lowering `DIV` mid-count forces a step on the next enabled cycle rather than waiting for a counter roll-over.
- Wrap on a step:
  - Up from N-1 gives 0; down from 0 gives N-1.
  - `WRAP` pulses high for 1 cycle, asserted on the same edge as the wrapped `IDX`/`Y`.
  - Arithmetic is modulo N, not modulo 2^M.
- Otherwise, with `EN` high: `cnt <= cnt + 1`.
- With `EN` low: `cnt`, `IDX` and `Y` hold, and `WRAP` and `ERR` are 0.
- `DIV = 0`: the index steps every enabled cycle.
- `DIR` is sampled only on a step edge; toggling it between steps has no other effect.
- No combinational paths from inputs to outputs.

## Timing
- All outputs are registered, with 1-cycle latency from the sampled inputs.
- `LOAD` asserted in cycle k gives `IDX = SEL` and the new `Y` visible after edge k.
- Step period is `DIV+1` enabled cycles. From reset release with `EN` high:
  - The first step edge is the (`DIV+1`)-th rising edge.
  - `IDX = 1` after that edge.
- `WRAP` and `ERR` are high for exactly one cycle and are never asserted together.
- `RESET` asserted for one edge is sufficient; outputs show reset values after that edge.
- `RESET` and `LOAD` together: reset wins and the load is discarded.
- `LOAD` together with a due step: the load wins, and the step is not carried over.

## Configuration
- Macro `ONEHOT_SCANNER_BLANK_EN`.
- Defined:
  - The `BLANK` input port exists.
  - While `BLANK` is high, the registered `Y` is all zeros from the next edge.
  - `IDX`, `cnt`, `WRAP` and `ERR` continue unaffected.
  - Deasserting `BLANK` restores `Y = 1 << IDX` on the next edge.
  - Used for brightness PWM and ghosting suppression.
- Undefined:
  - No `BLANK` port.
  - `Y` is always exactly one-hot.
- Reset behaviour is identical in both builds.

## Test plan
- **Reset:** N=8, `RESET` for 2 cycles with `LOAD=1, SEL=5` → `IDX=0`, `Y=8'h01`, `WRAP=0`, `ERR=0`.
- **Scan up with wrap:** N=8, `DIV=2`, `EN=1`, `DIR=0`, 24 cycles → `IDX` advances every 3 cycles through 0…7 and wraps to 0; `WRAP` is high for 1 cycle with `Y=8'h01`.
- **Scan down and DIV=0, non-power-of-two N:** N=6, `DIR=1` from `IDX=0` → next `IDX=5`, `Y=6'b100000`, `WRAP=1`. With `DIV=0` the sequence is 5,4,3,2,1,0,5 on consecutive cycles.
- **Load rejection:** N=6, `LOAD` with `SEL=3` → `IDX=3`, `Y=6'b001000`. `LOAD` with `SEL=7` → `IDX` stays 3 and `ERR` pulses for 1 cycle.
- **Priority and hold:**
  - `LOAD` coinciding with a due step → `IDX=SEL`, no extra step, `cnt` restarts.
  - `EN=0` for 10 cycles → `IDX`, `Y` and `cnt` frozen.
  - Lowering `DIV` from 100 to 1 when `cnt=50` → step on the next enabled cycle.
- **Blanking (macro defined):** `BLANK=1` for 5 cycles while stepping → `Y=0` from the next edge while `IDX` keeps advancing. `BLANK=0` → `Y=1<<IDX` one edge later.

Source files
------------

// File: rtl/onehot_scanner.sv
// Registered one-hot scan decoder: Y = 1 << IDX, stepped by a DIV+1 prescaler or loaded from SEL.
// Latency: 1 cycle from sampled inputs to all outputs; no input-to-output combinational paths.
// Backpressure: none; EN low freezes the prescaler and index. Optional BLANK port: ONEHOT_SCANNER_BLANK_EN.
module onehot_scanner #(
    parameter int N     = 8,
    parameter int M     = $clog2(N),
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [M-1:0]     SEL,
    input  logic             DIR,
    input  logic [DIV_W-1:0] DIV,
`ifdef ONEHOT_SCANNER_BLANK_EN
    input  logic             BLANK,
`endif
    output logic [N-1:0]     Y,
    output logic [M-1:0]     IDX,
    output logic             WRAP,
    output logic             ERR
);

    localparam logic [M-1:0]     IDX_LAST = M'(N - 1);
    localparam logic [M-1:0]     IDX_ONE  = M'(1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
    localparam logic [N-1:0]     Y_FIRST  = N'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [M-1:0]     idx_nxt;
    logic [N-1:0]     y_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    logic             sel_ok;
    logic             step_due;

    // With a power-of-two N every SEL encoding is a valid index.
    generate
        if ((1 << M) == N) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_range
            assign sel_ok = (SEL <= IDX_LAST);
        end
    endgenerate

    // >= rather than == so a DIV lowered below cnt steps immediately.
    assign step_due = (cnt >= DIV);

    always_comb begin
        idx_nxt  = IDX;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (LOAD) begin
            cnt_nxt = '0;
            if (sel_ok) begin
                idx_nxt = SEL;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (EN) begin
            if (step_due) begin
                cnt_nxt = '0;
                if (DIR) begin
                    if (IDX == '0) begin
                        idx_nxt  = IDX_LAST;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = IDX - IDX_ONE;
                    end
                end else begin
                    if (IDX == IDX_LAST) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = IDX + IDX_ONE;
                    end
                end
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end

        y_nxt = Y_FIRST << idx_nxt;
`ifdef ONEHOT_SCANNER_BLANK_EN
        if (BLANK) begin
            y_nxt = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            IDX  <= '0;
            Y    <= Y_FIRST;
            cnt  <= '0;
            WRAP <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            IDX  <= idx_nxt;
            Y    <= y_nxt;
            cnt  <= cnt_nxt;
            WRAP <= wrap_nxt;
            ERR  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_onehot_scanner.sv
// Bench for onehot_scanner: an N=8 and an N=6 instance share one stimulus stream and are
// compared every cycle against a modulo-N reference model.
module tb_onehot_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [2:0]  sel;
    logic        dir;
    logic [15:0] div;
    logic        blank;

    logic [7:0]  y8;
    logic [2:0]  idx8;
    logic        wrap8;
    logic        err8;
    logic [5:0]  y6;
    logic [2:0]  idx6;
    logic        wrap6;
    logic        err6;

    int n_checks = 0;
    int n_errors = 0;

    int nn[2]     = '{8, 6};
    int m_idx[2];
    int m_cnt[2];
    int m_y[2];
    int m_wrap[2];
    int m_err[2];

    always #5 clk = ~clk;

    onehot_scanner #(.N(8), .DIV_W(16)) u_dut8 (
        .CLK   (clk),
        .RESET (rst),
        .EN    (en),
        .LOAD  (load),
        .SEL   (sel),
        .DIR   (dir),
        .DIV   (div),
`ifdef ONEHOT_SCANNER_BLANK_EN
        .BLANK (blank),
`endif
        .Y     (y8),
        .IDX   (idx8),
        .WRAP  (wrap8),
        .ERR   (err8)
    );

    onehot_scanner #(.N(6), .DIV_W(16)) u_dut6 (
        .CLK   (clk),
        .RESET (rst),
        .EN    (en),
        .LOAD  (load),
        .SEL   (sel),
        .DIR   (dir),
        .DIV   (div),
`ifdef ONEHOT_SCANNER_BLANK_EN
        .BLANK (blank),
`endif
        .Y     (y6),
        .IDX   (idx6),
        .WRAP  (wrap6),
        .ERR   (err6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference behaviour of one scanner of size nn[k] for the inputs present at this edge.
    task automatic model_edge(input int k);
        int n;
        bit blank_now;
        n = nn[k];
`ifdef ONEHOT_SCANNER_BLANK_EN
        blank_now = blank;
`else
        blank_now = 1'b0;
`endif
        m_wrap[k] = 0;
        m_err[k]  = 0;
        if (rst) begin
            m_idx[k] = 0;
            m_cnt[k] = 0;
            m_y[k]   = 1;
            return;
        end
        if (load) begin
            m_cnt[k] = 0;
            if (int'(sel) < n) m_idx[k] = int'(sel);
            else               m_err[k] = 1;
        end else if (en) begin
            if (m_cnt[k] >= int'(div)) begin
                m_cnt[k] = 0;
                if (dir) begin
                    m_wrap[k] = (m_idx[k] == 0);
                    m_idx[k]  = (m_idx[k] + n - 1) % n;
                end else begin
                    m_wrap[k] = (m_idx[k] == n - 1);
                    m_idx[k]  = (m_idx[k] + 1) % n;
                end
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
        m_y[k] = blank_now ? 0 : (1 << m_idx[k]);
    endtask

    // One clock: edge, model update, then compare both instances 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("idx8",  idx8,  m_idx[0]);
        check("y8",    y8,    m_y[0]);
        check("wrap8", wrap8, m_wrap[0]);
        check("err8",  err8,  m_err[0]);
        check("idx6",  idx6,  m_idx[1]);
        check("y6",    y6,    m_y[1]);
        check("wrap6", wrap6, m_wrap[1]);
        check("err6",  err6,  m_err[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int wraps;
        int down_seq[7] = '{5, 4, 3, 2, 1, 0, 5};

        rst = 1'b1; en = 1'b1; load = 1'b1; sel = 3'd5; dir = 1'b0; div = 16'd0; blank = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_y[k] = 1; m_wrap[k] = 0; m_err[k] = 0;
        end

        // Reset held two cycles with a pending load
        cyc();
        cyc();
        check("rst_idx8", idx8, 0);
        check("rst_y8",   y8,   8'h01);
        check("rst_y6",   y6,   6'h01);
        check("rst_err8", err8, 0);

        // Scan up, DIV=2, 24 cycles: eight steps, one wrap back to 0
        rst = 1'b0; load = 1'b0; div = 16'd2; dir = 1'b0;
        wraps = 0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (i == 2) check("first_step8", idx8, 1);
            if (wrap8) begin
                wraps++;
                check("wrap_y8", y8, 8'h01);
            end
        end
        check("wrapcnt8", wraps, 1);
        check("scan_end8", idx8, 0);

        // Scan down every cycle from 0
        do_reset();
        dir = 1'b1; div = 16'd0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("down6", idx6, down_seq[i]);
            if (i == 0) begin
                check("down6_y", y6, 6'b100000);
                check("down6_wrap", wrap6, 1);
            end
        end

        // Loads, including an out-of-range select on N=6
        en = 1'b0; load = 1'b1; sel = 3'd3;
        cyc();
        check("load3_y6", y6, 6'b001000);
        sel = 3'd7;
        cyc();
        check("rej_idx6", idx6, 3);
        check("rej_err6", err6, 1);
        check("acc_idx8", idx8, 7);
        load = 1'b0;
        cyc();
        check("err6_pulse", err6, 0);

        // Load coincident with a due step
        do_reset();
        en = 1'b1; dir = 1'b0; div = 16'd2;
        cyc();
        cyc();
        load = 1'b1; sel = 3'd4;
        cyc();
        check("load_due8", idx8, 4);
        load = 1'b0;
        cyc();
        cyc();
        check("no_carry8", idx8, 4);
        cyc();
        check("restart8", idx8, 5);

        // Hold with EN low
        cyc();
        en = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("hold8", idx8, 5);
        en = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // Lower DIV from 100 to 1 at cnt=50
        do_reset();
        div = 16'd100;
        for (int i = 0; i < 50; i++) cyc();
        check("pre_drop8", idx8, 0);
        div = 16'd1;
        cyc();
        check("div_drop8", idx8, 1);

`ifdef ONEHOT_SCANNER_BLANK_EN
        div = 16'd0;
        blank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("blank_y8", y8, 0);
        end
        blank = 1'b0;
        cyc();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 9) < 8);
            sel   = 3'($urandom_range(0, 7));
            dir   = ($urandom_range(0, 3) == 0) ? ~dir : dir;
            if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 5));
`ifdef ONEHOT_SCANNER_BLANK_EN
            blank = ($urandom_range(0, 7) == 0);
`endif
            cyc();
            check("excl8", wrap8 & err8, 0);
            check("excl6", wrap6 & err6, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
